// File: rtl/ct_pack_if.sv
// ct_pack_if: control, sub-unit and shared-RAM signals of the ciphertext pack sequencer
interface ct_pack_if;
  logic        start, busy, done, err;
  logic        enc_start, enc_done, enc_we;
  logic [9:0]  enc_addr;
  logic [7:0]  enc_di;
  logic [8:0]  enc_poly_addr;
  logic        cmp_start, cmp_done, cmp_we;
  logic [7:0]  cmp_addr, cmp_di;
  logic [8:0]  cmp_poly_addr;
  logic [10:0] ct_addr;
  logic [7:0]  ct_di;
  logic        ct_we;
  logic [8:0]  poly_addr;
  logic        poly_sel;
  modport master(
    input  start, enc_done, enc_addr, enc_di, enc_we, enc_poly_addr,
           cmp_done, cmp_addr, cmp_di, cmp_we, cmp_poly_addr,
    output busy, done, err, enc_start, cmp_start, ct_addr, ct_di, ct_we, poly_addr, poly_sel
  );
  modport slave(
    output start, enc_done, enc_addr, enc_di, enc_we, enc_poly_addr,
           cmp_done, cmp_addr, cmp_di, cmp_we, cmp_poly_addr,
    input  busy, done, err, enc_start, cmp_start, ct_addr, ct_di, ct_we, poly_addr, poly_sel
  );
endinterface

// File: rtl/ct_pack_sequencer.sv
// ct_pack_sequencer: runs encoder then compressor over shared RAM ports, checks write counts
module ct_pack_sequencer #(
  parameter int ENC_BYTES = 896,
  parameter int CMP_BYTES = 192,
  parameter int CMP_BASE  = 896,
  parameter int TIMEOUT   = 4096
) (
  input logic clk,
  input logic rst,
  ct_pack_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ENC_GO, ENC_RUN, CMP_GO, CMP_RUN, FINISH} state_t;
  state_t state, state_n;
  logic [10:0] cnt, cnt_n, cnt_inc, exp_bytes;
  logic [TW-1:0] tmr, tmr_n;
  logic err_q, err_n, we_run, done_run, enc_ph, cmp_ph;
  assign enc_ph = state == ENC_GO || state == ENC_RUN;
  assign cmp_ph = state == CMP_GO || state == CMP_RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tmr   <= tmr_n;
      err_q <= err_n;
    end
  end
  always_comb begin
    we_run    = state == ENC_RUN ? bus.enc_we : state == CMP_RUN ? bus.cmp_we : 1'b0;
    done_run  = state == ENC_RUN ? bus.enc_done : state == CMP_RUN ? bus.cmp_done : 1'b0;
    exp_bytes = state == ENC_RUN ? 11'(ENC_BYTES) : 11'(CMP_BYTES);
    cnt_inc   = (&cnt) ? cnt : cnt + {10'd0, we_run};
    state_n   = state;
    cnt_n     = cnt;
    tmr_n     = tmr;
    err_n     = err_q;
    case (state)
      IDLE: if (bus.start) begin
        state_n = ENC_GO;
        cnt_n   = '0;
        tmr_n   = '0;
        err_n   = 1'b0;
      end
      ENC_GO: state_n = ENC_RUN;
      CMP_GO: state_n = CMP_RUN;
      ENC_RUN, CMP_RUN: begin
        cnt_n = cnt_inc;
        tmr_n = tmr + TW'(1);
        // the write coincident with done is already folded into cnt_inc
        if (done_run) begin
          err_n   = err_q | (cnt_inc != exp_bytes);
          cnt_n   = '0;
          tmr_n   = '0;
          state_n = state == ENC_RUN ? CMP_GO : FINISH;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = FINISH;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy      = state != IDLE;
    bus.done      = state == FINISH;
    bus.err       = err_q;
    bus.enc_start = state == ENC_GO;
    bus.cmp_start = state == CMP_GO;
    bus.ct_we     = enc_ph ? bus.enc_we : cmp_ph & bus.cmp_we;
    bus.ct_addr   = enc_ph ? {1'b0, bus.enc_addr} : cmp_ph ? 11'(CMP_BASE) + {3'd0, bus.cmp_addr} : '0;
    bus.ct_di     = enc_ph ? bus.enc_di : cmp_ph ? bus.cmp_di : '0;
    bus.poly_addr = enc_ph ? bus.enc_poly_addr : cmp_ph ? bus.cmp_poly_addr : '0;
    bus.poly_sel  = cmp_ph;
  end
endmodule

// File: tb/tb_ct_pack_sequencer.sv
// tb_ct_pack_sequencer: randomized sub-unit models checked against a transaction-level reference
module tb_ct_pack_sequencer;
  localparam int TIMEOUT = 4096;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ct_pack_if bus();
  ct_pack_sequencer dut(.clk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0, cyc = 0;
  int owner = 0, t0 = 0, m_n = 0, st_cyc = 0, done_cyc = 0;
  bit go = 0, fin = 0, m_err = 0;
  bit want_start, finished, post_rst, probe_cfg, probe_pend, probe_now;
  int enc_n, cmp_n, enc_i, cmp_i;
  bit enc_hang, enc_coinc, enc_act, cmp_act, rst_mid;
  int wr_cnt[2048];
  int n_enc_st, n_cmp_st, n_done, err_at_done;
  int p_addr, p_paddr, p_sel, p_we, r_busy, r_we;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic noise_enc();
    bus.enc_we = 1'($urandom); bus.enc_done = ($urandom_range(7) == 0);
    bus.enc_addr = 10'($urandom); bus.enc_di = 8'($urandom); bus.enc_poly_addr = 9'($urandom);
  endtask
  task automatic noise_cmp();
    bus.cmp_we = 1'($urandom); bus.cmp_done = ($urandom_range(7) == 0);
    bus.cmp_addr = 8'($urandom); bus.cmp_di = 8'($urandom); bus.cmp_poly_addr = 9'($urandom);
  endtask
  task automatic drive();
    rst = 1'b0;
    bus.start = 1'b0;
    if (want_start) begin bus.start = 1'b1; want_start = 0; end
    else if (owner != 0 || fin) bus.start = ($urandom_range(15) == 0);
    if (rst_mid && cmp_act && cmp_i == 50) begin rst = 1'b1; rst_mid = 0; end
    {bus.enc_we, bus.enc_done, bus.enc_addr, bus.enc_di, bus.enc_poly_addr} = '0;
    {bus.cmp_we, bus.cmp_done, bus.cmp_addr, bus.cmp_di, bus.cmp_poly_addr} = '0;
    if (enc_act) begin
      if (enc_i < enc_n && $urandom_range(3) != 0) begin
        bus.enc_we = 1'b1; bus.enc_addr = 10'(enc_i); bus.enc_di = 8'($urandom);
        bus.enc_poly_addr = 9'(enc_i / 2); enc_i++;
        if (enc_i == enc_n && enc_coinc && !enc_hang) begin bus.enc_done = 1'b1; enc_act = 0; end
      end else if (enc_i == enc_n && !enc_hang) begin bus.enc_done = 1'b1; enc_act = 0; end
    end else if (owner != 1) noise_enc();
    if (cmp_act) begin
      if (probe_pend) begin
        bus.cmp_addr = 8'd5; bus.cmp_poly_addr = 9'd300; probe_pend = 0; probe_now = 1;
      end else if (cmp_i < cmp_n && $urandom_range(3) != 0) begin
        bus.cmp_we = 1'b1; bus.cmp_addr = 8'(cmp_i); bus.cmp_di = 8'($urandom);
        bus.cmp_poly_addr = 9'(256 + cmp_i); cmp_i++;
        if (cmp_i == cmp_n) begin bus.cmp_done = 1'b1; cmp_act = 0; end
      end
    end else if (owner != 2) noise_cmp();
    if (probe_now) bus.enc_we = 1'b1;
  endtask
  task automatic compare();
    int e_we, e_addr, e_di, e_pa;
    e_we   = owner == 1 ? int'(bus.enc_we) : owner == 2 ? int'(bus.cmp_we) : 0;
    e_addr = owner == 1 ? int'(bus.enc_addr) : owner == 2 ? 896 + int'(bus.cmp_addr) : 0;
    e_di   = owner == 1 ? int'(bus.enc_di) : owner == 2 ? int'(bus.cmp_di) : 0;
    e_pa   = owner == 1 ? int'(bus.enc_poly_addr) : owner == 2 ? int'(bus.cmp_poly_addr) : 0;
    chk("busy", bus.busy, int'(owner != 0 || fin));
    chk("done", bus.done, int'(fin));
    chk("err", bus.err, int'(m_err));
    chk("enc_start", bus.enc_start, int'(owner == 1 && go));
    chk("cmp_start", bus.cmp_start, int'(owner == 2 && go));
    chk("ct_we", bus.ct_we, e_we);
    chk("ct_addr", bus.ct_addr, e_addr);
    chk("ct_di", bus.ct_di, e_di);
    chk("poly_addr", bus.poly_addr, e_pa);
    chk("poly_sel", bus.poly_sel, int'(owner == 2));
    if (bus.ct_we) wr_cnt[bus.ct_addr]++;
    if (bus.enc_start) begin n_enc_st++; enc_act = 1; enc_i = 0; end
    if (bus.cmp_start) begin n_cmp_st++; cmp_act = 1; cmp_i = 0; probe_pend = probe_cfg; end
    if (bus.done) begin n_done++; done_cyc = cyc; err_at_done = int'(bus.err); end
    if (probe_now) begin
      p_addr = int'(bus.ct_addr); p_paddr = int'(bus.poly_addr);
      p_sel = int'(bus.poly_sel); p_we = int'(bus.ct_we); probe_now = 0;
    end
    if (post_rst) begin r_busy = int'(bus.busy); r_we = int'(bus.ct_we); post_rst = 0; end
  endtask
  task automatic model_update();
    bit w, d;
    if (rst) begin
      owner = 0; go = 0; fin = 0; m_err = 0; enc_act = 0; cmp_act = 0;
      finished = 1; post_rst = 1;
    end else if (fin) begin
      fin = 0; finished = 1;
    end else if (owner == 0) begin
      if (bus.start) begin m_err = 0; owner = 1; go = 1; st_cyc = cyc; end
    end else if (go) begin
      go = 0; t0 = cyc + 1; m_n = 0;
    end else begin
      w = owner == 1 ? bus.enc_we : bus.cmp_we;
      d = owner == 1 ? bus.enc_done : bus.cmp_done;
      if (w && m_n < 2047) m_n++;
      if (d) begin
        if (m_n != (owner == 1 ? 896 : 192)) m_err = 1;
        if (owner == 1) begin owner = 2; go = 1; end
        else begin owner = 0; fin = 1; end
      end else if (cyc - t0 == TIMEOUT - 1) begin
        m_err = 1; owner = 0; fin = 1; enc_act = 0; cmp_act = 0;
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    drive();
    #1;
    compare();
    model_update();
    cyc++;
  endtask
  task automatic run_case(input int en, input int cn, input bit hang, input bit rmid, input bit probe);
    enc_n = en; cmp_n = cn; enc_hang = hang; enc_coinc = 1'($urandom); rst_mid = rmid;
    probe_cfg = probe; probe_pend = 0; probe_now = 0; enc_act = 0; cmp_act = 0;
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    n_enc_st = 0; n_cmp_st = 0; n_done = 0; err_at_done = -1; done_cyc = -1;
    p_addr = -1; p_paddr = -1; p_sel = -1; p_we = -1; r_busy = -1; r_we = -1;
    finished = 0; want_start = 1;
    for (int k = 0; k < 12000 && !finished; k++) step();
    chk("cycle_bound", int'(finished), 1);
    repeat (2) step();
  endtask
  task automatic check_cover(input string nm);
    int holes = 0, extra = 0;
    for (int a = 0; a < 2048; a++)
      if (a < 1088) holes += int'(wr_cnt[a] != 1); else extra += wr_cnt[a];
    chk({nm, "_cover"}, holes, 0);
    chk({nm, "_extra"}, extra, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    {bus.enc_we, bus.enc_done, bus.enc_addr, bus.enc_di, bus.enc_poly_addr} = '0;
    {bus.cmp_we, bus.cmp_done, bus.cmp_addr, bus.cmp_di, bus.cmp_poly_addr} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_enc_start", bus.enc_start, 0);
    chk("rst_cmp_start", bus.cmp_start, 0);
    chk("rst_ct_we", bus.ct_we, 0);
    chk("rst_ct_addr", bus.ct_addr, 0);
    chk("rst_poly_addr", bus.poly_addr, 0);
    chk("rst_poly_sel", bus.poly_sel, 0);
    run_case(896, 192, 0, 0, 1);
    check_cover("nom");
    chk("nom_done", n_done, 1);
    chk("nom_err", err_at_done, 0);
    chk("nom_enc_start", n_enc_st, 1);
    chk("nom_cmp_start", n_cmp_st, 1);
    chk("probe_ct_addr", p_addr, 901);
    chk("probe_poly_addr", p_paddr, 300);
    chk("probe_poly_sel", p_sel, 1);
    chk("probe_ct_we", p_we, 0);
    run_case(896, 191, 0, 0, 0);
    chk("short_cmp_done", n_done, 1);
    chk("short_cmp_err", err_at_done, 1);
    run_case(896, 192, 0, 0, 0);
    chk("reclear_err", err_at_done, 0);
    check_cover("again");
    run_case(895, 192, 0, 0, 0);
    chk("short_enc_err", err_at_done, 1);
    chk("short_enc_cmp_start", n_cmp_st, 1);
    run_case(896, 192, 1, 0, 0);
    chk("to_err", err_at_done, 1);
    chk("to_done", n_done, 1);
    chk("to_cmp_start", n_cmp_st, 0);
    chk("to_cycle", int'(done_cyc - st_cyc >= TIMEOUT + 1 && done_cyc - st_cyc <= TIMEOUT + 3), 1);
    run_case(896, 192, 0, 1, 0);
    chk("rmid_done", n_done, 0);
    chk("rmid_busy", r_busy, 0);
    chk("rmid_ct_we", r_we, 0);
    run_case(896, 192, 0, 0, 1);
    check_cover("post_rst");
    chk("post_rst_done", n_done, 1);
    chk("post_rst_err", err_at_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
